// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared constants, stage record and register-file read helper
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    localparam int XLEN     = 32;
    localparam int NREG     = 32;
    localparam int REGIDX_W = $clog2(NREG);

    localparam logic [XLEN-1:0] c_RF_BASE = 32'h1000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            valid;
    } stage_t;

    // x0 is hard-wired to zero; every other entry is its index offset from the base
    function automatic logic [XLEN-1:0] rf_read(input logic [REGIDX_W-1:0] idx);
        logic [XLEN-1:0] v;
        if (idx == '0) begin
            v = '0;
        end else begin
            v = c_RF_BASE + {{(XLEN-REGIDX_W){1'b0}}, idx};
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_if
// Description : Pipeline control inputs and EX-stage result outputs
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_if;
    import pipeline_pkg::*;

    logic            stall_if;
    logic            stall_id;
    logic            flush_if;
    logic            flush_id;
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] regA;
    logic [XLEN-1:0] regB;

    modport master (
        output stall_if, stall_id, flush_if, flush_id, pc_in,
        input  pc_out, regA, regB
    );

    modport slave (
        input  stall_if, stall_id, flush_if, flush_id, pc_in,
        output pc_out, regA, regB
    );

endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : One {pc, valid} pipeline register with hold, bubble and flush
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipeline_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   reset,
    input  wire logic   i_hold,
    input  wire logic   i_bubble,
    input  wire logic   i_flush,
    input  wire stage_t i_d,
    output stage_t      o_q
);

    stage_t r_q;

    // Flush only kills valid; the pc field keeps following the hold/load path
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else begin
            if (!i_hold) begin
                r_q.pc <= i_bubble ? '0 : i_d.pc;
            end
            if (i_flush) begin
                r_q.valid <= 1'b0;
            end else if (!i_hold) begin
                r_q.valid <= i_bubble ? 1'b0 : i_d.valid;
            end
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_top.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_top
// Description : Three-stage IF/ID/EX pipeline with register-file operand read
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_top
    import pipeline_pkg::*;
(
    input  wire logic clk,
    input  wire logic reset,
    pipeline_if.slave bus
);

    stage_t                r_if;
    stage_t                r_id;
    stage_t                r_ex;
    stage_t                w_if_d;
    logic                  w_if_hold;
    logic [REGIDX_W-1:0]   w_rs1;
    logic [REGIDX_W-1:0]   w_rs2;
    logic [XLEN-1:0]       r_reg_a;
    logic [XLEN-1:0]       r_reg_b;

    assign w_if_hold = bus.stall_if | bus.stall_id;
    assign w_if_d    = '{pc: bus.pc_in, valid: 1'b1};

    pipe_stage_reg u_if_stage (
        .clk      (clk),
        .reset    (reset),
        .i_hold   (w_if_hold),
        .i_bubble (1'b0),
        .i_flush  (bus.flush_if),
        .i_d      (w_if_d),
        .o_q      (r_if)
    );

    pipe_stage_reg u_id_stage (
        .clk      (clk),
        .reset    (reset),
        .i_hold   (bus.stall_id),
        .i_bubble (bus.stall_if),
        .i_flush  (bus.flush_id),
        .i_d      (r_if),
        .o_q      (r_id)
    );

    pipe_stage_reg u_ex_stage (
        .clk      (clk),
        .reset    (reset),
        .i_hold   (1'b0),
        .i_bubble (bus.stall_id),
        .i_flush  (1'b0),
        .i_d      (r_id),
        .o_q      (r_ex)
    );

    // Register indices come straight from the word address; rs2 wraps in 5 bits
    assign w_rs1 = r_id.pc[6:2];
    assign w_rs2 = w_rs1 + 5'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_reg_a <= '0;
            r_reg_b <= '0;
        end else if (bus.stall_id) begin
            r_reg_a <= '0;
            r_reg_b <= '0;
        end else begin
            r_reg_a <= rf_read(w_rs1);
            r_reg_b <= rf_read(w_rs2);
        end
    end

    assign bus.pc_out = r_ex.valid ? r_ex.pc : '0;
    assign bus.regA   = r_ex.valid ? r_reg_a : '0;
    assign bus.regB   = r_ex.valid ? r_reg_b : '0;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_top
// Description : Randomized bench for pipeline_top against a stage-level model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_top;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    pipeline_if bus();

    pipeline_top dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] rf   [32];
    logic [31:0] m_pc [3];
    logic        m_v  [3];

    logic [31:0] watch_a, watch_b;
    int          cnt_a, cnt_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_pc[i] = '0;
            m_v[i]  = 1'b0;
        end
    endtask

    // One clock edge of the pipeline, written from the stage rules
    task automatic model_edge();
        logic [31:0] ipc, dpc;
        logic        iv, dv;
        ipc = m_pc[0]; iv = m_v[0];
        dpc = m_pc[1]; dv = m_v[1];
        if (bus.stall_id) begin
            m_v[2] = 1'b0;
        end else begin
            m_v[2]  = dv;
            m_pc[2] = dpc;
        end
        if (!bus.stall_id) begin
            if (bus.stall_if) begin
                m_v[1] = 1'b0;
            end else begin
                m_v[1]  = iv;
                m_pc[1] = ipc;
            end
        end
        if (bus.flush_id) m_v[1] = 1'b0;
        if (!(bus.stall_if || bus.stall_id)) begin
            m_pc[0] = bus.pc_in;
            m_v[0]  = 1'b1;
        end
        if (bus.flush_if) m_v[0] = 1'b0;
    endtask

    task automatic check_model();
        logic [31:0] e_pc, e_a, e_b;
        int idx;
        e_pc = '0; e_a = '0; e_b = '0;
        if (m_v[2]) begin
            idx  = int'((m_pc[2] >> 2) & 32'd31);
            e_pc = m_pc[2];
            e_a  = rf[idx];
            e_b  = rf[(idx + 1) % 32];
        end
        chk("pc_out", bus.pc_out, e_pc);
        chk("regA",   bus.regA,   e_a);
        chk("regB",   bus.regB,   e_b);
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) model_clear();
        else        model_edge();
        #1;
        check_model();
        if (bus.pc_out == watch_a) cnt_a++;
        if (bus.pc_out == watch_b) cnt_b++;
    endtask

    task automatic drv(input logic si, input logic sd, input logic fi, input logic fd,
                       input logic [31:0] pc);
        bus.stall_if = si;
        bus.stall_id = sd;
        bus.flush_if = fi;
        bus.flush_id = fd;
        bus.pc_in    = pc;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pc"}, bus.pc_out, 32'h0);
        chk({tag, "_a"},  bus.regA,   32'h0);
        chk({tag, "_b"},  bus.regB,   32'h0);
    endtask

    initial begin
        rf[0] = 32'h0;
        for (int i = 1; i < 32; i++) rf[i] = 32'h1000_0000 + i;
        model_clear();
        watch_a = 32'hFFFF_FFFF; watch_b = 32'hFFFF_FFFF;
        cnt_a = 0; cnt_b = 0;
        drv(0, 0, 0, 0, 32'h0);

        #2 reset = 1'b0;
        #1 check_zero("reset");
        step(); step();
        reset = 1'b1;

        // Constant pc_in = 4: result appears after the third edge
        drv(0, 0, 0, 0, 32'h4);
        step(); step(); step();
        chk("lat_pc", bus.pc_out, 32'h4);
        chk("lat_a",  bus.regA,   32'h1000_0001);
        chk("lat_b",  bus.regB,   32'h1000_0002);

        drv(0, 0, 0, 0, 32'h0);
        step(); step(); step();
        chk("x0_a", bus.regA, 32'h0);
        chk("x0_b", bus.regB, 32'h1000_0001);

        drv(0, 0, 0, 0, 32'h7C);
        step(); step(); step();
        chk("wrap_pc", bus.pc_out, 32'h7C);
        chk("wrap_a",  bus.regA,   32'h1000_001F);
        chk("wrap_b",  bus.regB,   32'h0);

        // stall_if while pc_in moves 4 -> 8
        drv(0, 0, 0, 0, 32'h4);
        step();
        drv(1, 0, 0, 0, 32'h8); step(); step();
        drv(0, 0, 0, 0, 32'h8); step(); step(); step(); step();

        // stall_id for 3 cycles: held entries appear exactly once
        watch_a = 32'h10; watch_b = 32'h14; cnt_a = 0; cnt_b = 0;
        drv(0, 0, 0, 0, 32'h10); step();
        drv(0, 0, 0, 0, 32'h14); step();
        drv(0, 1, 0, 0, 32'h18); step(); step(); step();
        drv(0, 0, 0, 0, 32'h18); step(); step(); step(); step();
        chk("stall_id_once_10", cnt_a, 32'd1);
        chk("stall_id_once_14", cnt_b, 32'd1);

        // flush_if kills 0xC in IF
        watch_a = 32'hC; cnt_a = 0;
        drv(0, 0, 0, 0, 32'h30); step();
        drv(0, 0, 1, 0, 32'hC);  step();
        drv(0, 0, 0, 0, 32'h34); step(); step(); step(); step();
        chk("flush_if_gone", cnt_a, 32'd0);

        // flush_id with stall_if, then reset mid-stream
        drv(0, 0, 0, 0, 32'h40); step();
        drv(0, 0, 0, 0, 32'h44); step();
        drv(1, 0, 0, 1, 32'h48); step(); step();
        drv(0, 0, 0, 0, 32'h4C); step();
        #2 reset = 1'b0;
        #1 check_zero("async_rst");
        model_clear();
        step(); step();
        reset = 1'b1;
        step(); step(); step(); step();

        watch_a = 32'hFFFF_FFFF; watch_b = 32'hFFFF_FFFF;
        for (int n = 0; n < 600; n++) begin
            drv(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                $urandom());
            reset = ($urandom_range(0, 99) != 0);
            step();
        end
        reset = 1'b1;
        drv(0, 0, 0, 0, 32'h0);
        step(); step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_top.md
PIPELINE_TOP -- requirements
Module: pipeline_top

Interface
REQ-001 Parameters: XLEN, default 32, datapath width; NREG, default 32, register-file entries (read-only constants).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 stall_if  in  1  hold fetch stage.
REQ-005 stall_id  in  1  hold decode stage and everything upstream.
REQ-006 flush_if  in  1  kill the fetch-stage entry.
REQ-007 flush_id  in  1  kill the decode-stage entry.
REQ-008 pc_in  in  32  PC presented for fetch.
REQ-009 pc_out  out  32  PC of the instruction in the EX stage.
REQ-010 regA  out  32  rs1 operand of the EX-stage instruction.
REQ-011 regB  out  32  rs2 operand of the EX-stage instruction (full 32 bits).

Function
REQ-012 Three registered stages IF, ID, EX; each holds {pc[31:0], valid}.
REQ-013 IF stage: if_pc<=pc_in, if_valid<=1 each edge unless stall_if or stall_id is 1, in which case it holds.
REQ-014 ID stage: if stall_id, holds; else if stall_if, loads bubble (valid=0); else loads IF pc/valid.
REQ-015 EX stage: if stall_id, loads bubble; else loads ID pc, valid and operands.
REQ-016 Flush priority over stall: flush_if forces if_valid<=0 on that edge; flush_id forces id_valid<=0 on that edge; pc fields follow normal stall/load rules.
REQ-017 Decode: rs1=id_pc[6:2], rs2=(id_pc[6:2]+1) mod 32 (5-bit wrap, 31->0).
REQ-018 Register file is combinational read-only: x0=0; x[i]=32'h1000_0000+i for i=1..31.
REQ-019 EX latches regA=x[rs1], regB=x[rs2] from the ID stage.
REQ-020 When ex_valid=0, pc_out, regA, regB read 0.
REQ-021 Latency: pc_in sampled on edge k appears on pc_out/regA/regB after edge k+2, absent stalls/flushes.
REQ-022 Simultaneous stall_if and stall_id: IF and ID hold, EX receives bubble.
REQ-023 Simultaneous flush_id and stall_if: ID becomes bubble, IF holds.

Reset
REQ-024 reset=0 immediately clears all pc fields, valid bits and operand registers to 0, independent of clk.
REQ-025 During reset, and until the first valid entry reaches EX, pc_out=regA=regB=0.
REQ-026 Reset asserted mid-operation discards all in-flight entries; refill restarts per REQ-021.

Structure
REQ-027 Shared package holds XLEN, NREG, the register-file reset constant 32'h1000_0000 and the stage record typedef {pc, valid}.
REQ-028 One sub-module, pipe_stage_reg, implements a stage register with hold, bubble and flush controls; pipeline_top instantiates it three times plus the decode/register-file logic.

Verification
REQ-029 Reset, then pc_in=4 constant, no stalls -> after edge 3: pc_out=4, regA=32'h1000_0001, regB=32'h1000_0002.
REQ-030 pc_in=0 -> pc_out=0 with valid data, regA=0, regB=32'h1000_0001; pc_in=32'h7C -> regA=32'h1000_001F, regB=0 (wrap).
REQ-031 stall_if for 2 cycles with pc_in changing 4->8 -> IF holds 4, EX gets 2 bubbles (outputs 0), then 8 emerges in order.
REQ-032 stall_id for 3 cycles -> ID holds, EX outputs 0 for 3 cycles, held instruction then appears once, no duplication or loss.
REQ-033 flush_if one cycle with pc_in=C -> C never reaches pc_out; next PC follows normally.
REQ-034 flush_id and stall_if together for 2 cycles, then reset asserted mid-stream -> killed entries never appear; outputs go 0 at once on reset.
